// File: rtl/seq_pkg.sv
// Shared definitions for the serial 1101 pattern path.
// Used by the pattern transmitter and the sequence detector.
package seq_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP_W = 4;

  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_SHIFT = 2'd1;
  localparam seq_state_t ST_GAP   = 2'd2;
  localparam seq_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag.
// Shared by the bit, repetition and gap counters.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: bursts of PATTERN, MSB first,
// with a programmable idle gap between repetitions.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int             CNT_W   = DEF_CNT_W,
  parameter int             GAP_W   = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  seq_state_t       state;
  seq_state_t       state_d;
  logic [PAT_W-1:0] sreg;
  logic [GAP_W-1:0] gap_q;

  logic in_idle;
  logic in_shift;
  logic in_gap;
  logic in_done;
  logic start_ok;
  logic last_bit;
  logic more;
  logic reload;
  logic bit_zero;
  logic rep_zero;
  logic gap_zero;
  logic bit_load;
  logic bit_dec;
  logic gap_load;
  logic gap_dec;

  assign in_idle  = (state == ST_IDLE);
  assign in_shift = (state == ST_SHIFT);
  assign in_gap   = (state == ST_GAP);
  assign in_done  = (state == ST_DONE);

  assign start_ok = in_idle & start & (|rep_cnt);
  assign last_bit = in_shift & ~abort & bit_zero;
  assign more     = last_bit & ~rep_zero;
  assign reload   = (more & ~(|gap_q))
                  | (in_gap & ~abort & gap_zero);

  assign bit_load = start_ok | reload;
  assign bit_dec  = in_shift & ~abort & ~bit_zero;
  assign gap_load = more & (|gap_q);
  assign gap_dec  = in_gap & ~abort & ~gap_zero;

  // bits left in the current pattern, minus one
  seq_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load),
    .load_val (BIT_LAST),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  // repetitions still to start after the current one
  seq_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val (rep_cnt - CNT_W'(1)),
    .dec      (more),
    .zero     (rep_zero)
  );

  // idle cycles left in the gap, minus one
  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // next-state selection
  always_comb begin
    state_d = state;
    unique case (1'b1)
      in_idle: begin
        if (start)
          state_d = (|rep_cnt) ? ST_SHIFT : ST_DONE;
      end
      in_shift: begin
        if (abort)
          state_d = ST_DONE;
        else if (bit_zero) begin
          if (rep_zero)
            state_d = ST_DONE;
          else if (|gap_q)
            state_d = ST_GAP;
        end
      end
      in_gap: begin
        if (abort)
          state_d = ST_DONE;
        else if (gap_zero)
          state_d = ST_SHIFT;
      end
      in_done: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, captured gap and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gap_q <= '0;
      sreg  <= '0;
    end else begin
      state <= state_d;
      if (start_ok)
        gap_q <= gap;
      if (bit_load)
        sreg <= PATTERN;
      else if (in_shift & ~abort)
        sreg <= {sreg[PAT_W-2:0], 1'b0};
    end
  end

  // registered outputs reflect the state just processed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout       <= in_shift & ~abort & sreg[PAT_W-1];
      dout_valid <= in_shift & ~abort;
      busy       <= ~in_idle;
      done       <= in_done;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomised bench for seq_pattern_tx against a
// burst-level model of the output stream.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] rep_cnt;
  logic [3:0] gap;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  seq_pattern_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .rep_cnt    (rep_cnt),
    .gap        (gap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  // model: queue of {dout,valid,busy,done} per cycle
  logic [3:0] q[$];
  logic [3:0] exp_o = 4'b0;
  logic [3:0] pat   = 4'b1101;
  int         cyc   = 0;

  task automatic build(input int r, input int g);
    if (r == 0) begin
      q.push_back(4'b0011);
    end else begin
      for (int i = 0; i < r; i++) begin
        for (int b = 3; b >= 0; b--)
          q.push_back({pat[b], 3'b110});
        if (i < r - 1)
          for (int k = 0; k < g; k++)
            q.push_back(4'b0010);
      end
      q.push_back(4'b0011);
    end
  endtask

  initial begin
    logic       idle;
    logic [3:0] cur;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        exp_o = 4'b0;
      end else begin
        idle = (q.size() == 0);
        cur  = idle ? 4'b0 : q.pop_front();
        if (idle && start) begin
          build(int'(rep_cnt), int'(gap));
        end else if (!idle && abort && cur[1] && !cur[0]) begin
          q.delete();
          cur = 4'b0010;
          q.push_back(4'b0011);
        end
        exp_o = cur;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // per-cycle compare plus burst statistics
  logic [15:0] vbits;
  logic [2:0]  win;
  int nvalid, nbusy, det;
  int first_cyc, last_cyc, done_cyc;

  task automatic clear_mon();
    vbits = '0; win = '0;
    nvalid = 0; nbusy = 0; det = 0;
    first_cyc = 0; last_cyc = 0; done_cyc = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      chk("cycle", {28'd0, dout, dout_valid, busy, done},
          {28'd0, exp_o});
      if (dout_valid === 1'b1) begin
        if (nvalid == 0) first_cyc = cyc;
        last_cyc = cyc;
        nvalid++;
        vbits = {vbits[14:0], dout};
        if ({win, dout} == 4'b1101) det++;
        win = {win[1:0], dout};
      end
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) done_cyc = cyc;
    end
  end

  task automatic launch(input int r, input int g);
    @(negedge clk);
    clear_mon();
    start   = 1'b1;
    rep_cnt = 8'(r);
    gap     = 4'(g);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    logic got = 1'b0;
    if (done === 1'b1) got = 1'b1;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    rep_cnt = '0; gap = '0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    launch(1, 0);
    wait_done("single_to", 50);
    chk("single_bits", {28'd0, vbits[3:0]}, 32'b1101);
    chk("single_n", nvalid, 4);
    chk("single_lat", done_cyc - first_cyc, 4);
    chk("single_det", det, 1);
    idle_cycles(2);

    launch(3, 0);
    wait_done("b2b_to", 50);
    chk("b2b_bits", {20'd0, vbits[11:0]}, 32'b110111011101);
    chk("b2b_lat", done_cyc - first_cyc, 12);
    chk("b2b_det", det, 3);
    idle_cycles(2);

    launch(2, 3);
    wait_done("gap_to", 50);
    chk("gap_bits", {24'd0, vbits[7:0]}, 32'b11011101);
    chk("gap_n", nvalid, 8);
    chk("gap_lat", done_cyc - first_cyc, 11);
    idle_cycles(2);

    launch(0, 2);
    wait_done("zero_to", 10);
    chk("zero_n", nvalid, 0);
    chk("zero_busy", nbusy, 1);
    idle_cycles(2);

    launch(4, 0);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      if (dout_valid === 1'b1) cnt++;
      if (cnt < 2) @(negedge clk);
    end
    abort = 1'b1; start = 1'b1; rep_cnt = 8'd7;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    wait_done("abort_to", 10);
    chk("abort_n", nvalid, 2);
    chk("abort_lat", done_cyc - last_cyc, 2);
    idle_cycles(6);
    chk("abort_nostart", nvalid, 2);

    launch(5, 0);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) cnt++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", {31'd0, dout}, 32'd0);
    chk("arst_valid", {31'd0, dout_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    launch(1, 0);
    wait_done("arst_to", 50);
    chk("arst_bits", {28'd0, vbits[3:0]}, 32'b1101);

    for (int it = 0; it < 30; it++) begin
      logic got;
      launch($urandom_range(0, 5), $urandom_range(0, 4));
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        abort   = ($urandom_range(0, 7) == 0);
        start   = ($urandom_range(0, 7) == 0);
        rep_cnt = 8'($urandom_range(0, 5));
        @(negedge clk);
        if (done === 1'b1) got = 1'b1;
      end
      abort = 1'b0; start = 1'b0;
      chk("rand_to", {31'd0, got}, 32'd1);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
